// File: rtl/sopc_bus_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the single memory port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface sopc_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]              m_req;
    logic [NUM_MASTERS-1:0]              m_we;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata;
    logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be;
    logic [NUM_MASTERS-1:0]              m_gnt;
    logic [NUM_MASTERS-1:0]              m_rvalid;
    logic [DATA_WIDTH-1:0]               m_rdata;
    logic                                mem_ce;
    logic                                mem_we;
    logic [ADDR_WIDTH-1:0]               mem_addr;
    logic [DATA_WIDTH-1:0]               mem_wdata;
    logic [DATA_WIDTH/8-1:0]             mem_be;
    logic [DATA_WIDTH-1:0]               mem_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be, mem_rdata,
        output m_gnt, m_rvalid, m_rdata, mem_ce, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be, mem_rdata,
        input  m_gnt, m_rvalid, m_rdata, mem_ce, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/sopc_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_MASTERS requesters,
// one transaction at a time through IDLE -> ISSUE -> (WAIT for reads) -> IDLE.
module sopc_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    sopc_bus_arbiter_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = $clog2(NUM_MASTERS);
    localparam int CNT_W    = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       last_grant, winner, pick, idx;
    logic                   pick_valid;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [BE_WIDTH-1:0]    sel_be;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [BE_WIDTH-1:0]    be_q;
    logic [CNT_W-1:0]       cnt;
    logic                   wait_done;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [NUM_MASTERS-1:0] rvalid_q;
    logic [NUM_MASTERS-1:0] win_oh;

    assign win_oh    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner;
    assign wait_done = (cnt == CNT_W'(MEM_LATENCY - 1));

    // First requester found scanning upward from last_grant+1 wins; its fields are muxed here.
    always_comb begin
        pick_valid = 1'b0;
        pick       = last_grant;
        idx        = '0;
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_be     = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = IDX_W'((32'(last_grant) + k) % NUM_MASTERS);
            if (!pick_valid && bus.m_req[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
                sel_we     = bus.m_we[idx];
                sel_addr   = bus.m_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata  = bus.m_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
                sel_be     = bus.m_be[idx*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.mem_ce    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.m_gnt     = '0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.m_rvalid  = rvalid_q;
        bus.m_rdata   = rdata_q;
        case (state)
            IDLE: begin
                if (pick_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.mem_ce = 1'b1;
                bus.mem_we = we_q;
                bus.mem_be = be_q;
                bus.m_gnt  = win_oh;
                state_nxt  = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (wait_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
            winner     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            cnt        <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
        end else begin
            state    <= state_nxt;
            rvalid_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner  <= pick;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        be_q    <= sel_be;
                    end
                end
                ISSUE: begin
                    last_grant <= winner;
                    cnt        <= '0;
                end
                WAIT: begin
                    // Sample lands MEM_LATENCY cycles after ISSUE; the pulse appears the cycle after.
                    if (wait_done) begin
                        rdata_q  <= bus.mem_rdata;
                        rvalid_q <= win_oh;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sopc_bus_arbiter.sv
// Directed bench: a 2-master/latency-2 arbiter driven from a vector table, plus a
// 4-master/latency-1 arbiter and a mid-read reset exercised by hand-written sequences.
module tb_sopc_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] D   = 32'hDEAD_BEEF;
    localparam logic [31:0] R1  = 32'h1234_5678;
    localparam logic [31:0] X20 = 32'hA5A5_0020;
    localparam logic [31:0] X30 = 32'hA5A5_0030;

    sopc_bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) b2 ();
    sopc_bus_arbiter_if #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) b4 ();

    sopc_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2))
        u2 (.clk(clk), .rst(rst), .bus(b2));
    sopc_bus_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1))
        u4 (.clk(clk), .rst(rst), .bus(b4));

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h10) ? D : (a ^ 32'hA5A5_0000);
    endfunction

    // Memory models: read data is valid only in the cycle MEM_LATENCY after mem_ce.
    int dly2, dly4;
    logic [31:0] ra2, ra4;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly2 <= 0; ra2 <= '0;
        end else if (b2.mem_ce && !b2.mem_we) begin
            dly2 <= 1; ra2 <= b2.mem_addr;
        end else if (dly2 != 0 && dly2 < 2) begin
            dly2 <= dly2 + 1;
        end else begin
            dly2 <= 0;
        end
    end
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly4 <= 0; ra4 <= '0;
        end else if (b4.mem_ce && !b4.mem_we) begin
            dly4 <= 1; ra4 <= b4.mem_addr;
        end else begin
            dly4 <= 0;
        end
    end
    assign b2.mem_rdata = (dly2 == 2) ? rom(ra2) : 32'h0BAD_0BAD;
    assign b4.mem_rdata = (dly4 == 1) ? rom(ra4) : 32'h0BAD_0BAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("u2_gnt_onehot0", 32'($onehot0(b2.m_gnt)), 32'd1);
            check("u2_rvalid_onehot0", 32'($onehot0(b2.m_rvalid)), 32'd1);
            check("u4_gnt_onehot0", 32'($onehot0(b4.m_gnt)), 32'd1);
            check("u4_rvalid_onehot0", 32'($onehot0(b4.m_rvalid)), 32'd1);
        end
    end

    typedef struct {
        logic [1:0]  req, we;
        logic [31:0] a0, a1;
        logic [3:0]  be0, be1;
        logic [1:0]  gnt, rv;
        logic        ce, mwe;
        logic [31:0] maddr, mwd;
        logic [3:0]  mbe;
        logic [31:0] rd;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic [1:0] req, we, input logic [31:0] a0, a1,
                       input logic [3:0] be0, be1, input logic [1:0] gnt, rv,
                       input logic ce, mwe, input logic [31:0] maddr, mwd,
                       input logic [3:0] mbe, input logic [31:0] rd);
        vec_t v;
        v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.be0 = be0; v.be1 = be1;
        v.gnt = gnt; v.rv = rv; v.ce = ce; v.mwe = mwe; v.maddr = maddr;
        v.mwd = mwd; v.mbe = mbe; v.rd = rd;
        vt.push_back(v);
    endtask

    task automatic check_u2_zero(input string tag);
        check({tag, ".gnt"}, 32'(b2.m_gnt), 0);
        check({tag, ".rvalid"}, 32'(b2.m_rvalid), 0);
        check({tag, ".rdata"}, b2.m_rdata, 0);
        check({tag, ".ce"}, 32'(b2.mem_ce), 0);
        check({tag, ".mwe"}, 32'(b2.mem_we), 0);
        check({tag, ".maddr"}, b2.mem_addr, 0);
        check({tag, ".mwdata"}, b2.mem_wdata, 0);
        check({tag, ".mbe"}, 32'(b2.mem_be), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rv_seen;
        b2.m_req = '0; b2.m_we = '0; b2.m_addr = '0; b2.m_be = '0;
        b2.m_wdata = {R1, D};
        b4.m_req = '0; b4.m_we = '0; b4.m_be = '1;
        b4.m_addr = {32'h103, 32'h10, 32'h101, 32'h100};
        b4.m_wdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

        //   req    we     a0      a1      be0   be1    gnt    rv     ce    mwe   maddr   mwd  mbe   rdata
        add(2'b00, 2'b00, 32'h0,  32'h0,  4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  0,   4'h0, 0);
        add(2'b01, 2'b01, 32'h10, 32'h0,  4'hF, 4'h0, 2'b01, 2'b00, 1'b1, 1'b1, 32'h10, D,   4'hF, 0);
        add(2'b00, 2'b00, 32'h10, 32'h0,  4'hF, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h10, D,   4'h0, 0);
        add(2'b10, 2'b00, 32'h0,  32'h10, 4'h0, 4'hF, 2'b10, 2'b00, 1'b1, 1'b0, 32'h10, R1,  4'hF, 0);
        add(2'b00, 2'b00, 32'h0,  32'h10, 4'h0, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0, 32'h10, R1,  4'h0, 0);
        add(2'b00, 2'b00, 32'h0,  32'h10, 4'h0, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0, 32'h10, R1,  4'h0, 0);
        add(2'b00, 2'b00, 32'h0,  32'h10, 4'h0, 4'hF, 2'b00, 2'b10, 1'b0, 1'b0, 32'h10, R1,  4'h0, D);
        add(2'b00, 2'b00, 32'h0,  32'h10, 4'h0, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0, 32'h10, R1,  4'h0, D);
        add(2'b11, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b01, 2'b00, 1'b1, 1'b0, 32'h20, D,   4'h3, D);
        add(2'b11, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b00, 2'b00, 1'b0, 1'b0, 32'h20, D,   4'h0, D);
        add(2'b11, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b00, 2'b00, 1'b0, 1'b0, 32'h20, D,   4'h0, D);
        add(2'b11, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b00, 2'b01, 1'b0, 1'b0, 32'h20, D,   4'h0, X20);
        add(2'b11, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b10, 2'b00, 1'b1, 1'b0, 32'h30, R1,  4'hC, X20);
        add(2'b11, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b00, 2'b00, 1'b0, 1'b0, 32'h30, R1,  4'h0, X20);
        add(2'b11, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b00, 2'b00, 1'b0, 1'b0, 32'h30, R1,  4'h0, X20);
        add(2'b11, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b00, 2'b10, 1'b0, 1'b0, 32'h30, R1,  4'h0, X30);
        add(2'b11, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b01, 2'b00, 1'b1, 1'b0, 32'h20, D,   4'h3, X30);
        add(2'b00, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b00, 2'b00, 1'b0, 1'b0, 32'h20, D,   4'h0, X30);
        add(2'b00, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b00, 2'b00, 1'b0, 1'b0, 32'h20, D,   4'h0, X30);
        add(2'b00, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b00, 2'b01, 1'b0, 1'b0, 32'h20, D,   4'h0, X20);
        add(2'b00, 2'b00, 32'h20, 32'h30, 4'h3, 4'hC, 2'b00, 2'b00, 1'b0, 1'b0, 32'h20, D,   4'h0, X20);
        add(2'b10, 2'b10, 32'h0,  32'h44, 4'h0, 4'h5, 2'b10, 2'b00, 1'b1, 1'b1, 32'h44, R1,  4'h5, X20);
        add(2'b00, 2'b00, 32'h0,  32'h44, 4'h0, 4'h5, 2'b00, 2'b00, 1'b0, 1'b0, 32'h44, R1,  4'h0, X20);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_u2_zero("reset_u2");
        check("reset_u4.gnt", 32'(b4.m_gnt), 0);
        check("reset_u4.rdata", b4.m_rdata, 0);
        check("reset_u4.maddr", b4.mem_addr, 0);
        rst = 1'b1;

        foreach (vt[i]) begin
            b2.m_req  = vt[i].req;
            b2.m_we   = vt[i].we;
            b2.m_addr = {vt[i].a1, vt[i].a0};
            b2.m_be   = {vt[i].be1, vt[i].be0};
            @(posedge clk);
            #1;
            check($sformatf("v%0d.gnt", i), 32'(b2.m_gnt), 32'(vt[i].gnt));
            check($sformatf("v%0d.rvalid", i), 32'(b2.m_rvalid), 32'(vt[i].rv));
            check($sformatf("v%0d.ce", i), 32'(b2.mem_ce), 32'(vt[i].ce));
            check($sformatf("v%0d.mwe", i), 32'(b2.mem_we), 32'(vt[i].mwe));
            check($sformatf("v%0d.maddr", i), b2.mem_addr, vt[i].maddr);
            check($sformatf("v%0d.mwdata", i), b2.mem_wdata, vt[i].mwd);
            check($sformatf("v%0d.mbe", i), 32'(b2.mem_be), 32'(vt[i].mbe));
            check($sformatf("v%0d.rdata", i), b2.m_rdata, vt[i].rd);
        end

        // Four masters: make last_grant=1, then masters 1 and 3 contend continuously.
        b4.m_we  = 4'b1111;
        b4.m_req = 4'b0010;
        @(posedge clk); #1;
        check("rr4.first_gnt", 32'(b4.m_gnt), 32'b0010);
        check("rr4.first_addr", b4.mem_addr, 32'h101);
        b4.m_req = 4'b1010;
        @(posedge clk); #1;
        check("rr4.gap1", 32'(b4.m_gnt), 0);
        @(posedge clk); #1;
        check("rr4.gnt_m3", 32'(b4.m_gnt), 32'b1000);
        check("rr4.addr_m3", b4.mem_addr, 32'h103);
        @(posedge clk); #1;
        check("rr4.gap2", 32'(b4.m_gnt), 0);
        @(posedge clk); #1;
        check("rr4.gnt_m1", 32'(b4.m_gnt), 32'b0010);
        b4.m_req = '0;
        @(posedge clk); #1;

        // Four masters, latency 1: read by master 2 must complete 3 cycles after the request.
        b4.m_we  = 4'b0000;
        b4.m_req = 4'b0100;
        @(posedge clk); #1;
        check("rd4.gnt", 32'(b4.m_gnt), 32'b0100);
        b4.m_req = '0;
        n = 1;
        while (b4.m_rvalid == 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("rd4.latency", n, 3);
        check("rd4.rvalid", 32'(b4.m_rvalid), 32'b0100);
        check("rd4.rdata", b4.m_rdata, D);
        @(posedge clk); #1;
        check("rd4.rvalid_pulse", 32'(b4.m_rvalid), 0);
        check("rd4.rdata_hold", b4.m_rdata, D);

        // Reset asserted while a read by master 1 sits in WAIT.
        b2.m_req = 2'b10; b2.m_we = 2'b00; b2.m_addr = {32'h10, 32'h20}; b2.m_be = 2'b11 << 0;
        @(posedge clk); #1;
        check("rstw.gnt", 32'(b2.m_gnt), 32'b10);
        b2.m_req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_u2_zero("rstw_async");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rv_seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (b2.m_rvalid != 0) rv_seen++;
        end
        check("rstw.no_rvalid", rv_seen, 0);
        b2.m_req = 2'b11; b2.m_we = 2'b11;
        @(posedge clk); #1;
        check("rstw.first_gnt", 32'(b2.m_gnt), 32'b01);
        check("rstw.first_addr", b2.mem_addr, 32'h20);
        b2.m_req = '0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sopc_bus_arbiter.md
SOPC_BUS_ARBITER -- requirements
Module: sopc_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter NUM_MASTERS, default 2: number of requesting masters, range 2..8.
REQ-003 Parameter ADDR_WIDTH, default 32: address width.
REQ-004 Parameter DATA_WIDTH, default 32: data width, a multiple of 8.
REQ-005 Parameter MEM_LATENCY, default 1: cycles from mem_ce to valid mem_rdata, range 1..4.
REQ-006 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1: asynchronous active-low reset.
REQ-008 Port m_req, input, NUM_MASTERS: per-master request.
REQ-009 Port m_we, input, NUM_MASTERS: per-master write (1) or read (0).
REQ-010 Port m_addr, input, NUM_MASTERS*ADDR_WIDTH: packed addresses; master i occupies slice i.
REQ-011 Port m_wdata, input, NUM_MASTERS*DATA_WIDTH: packed write data.
REQ-012 Port m_be, input, NUM_MASTERS*DATA_WIDTH/8: packed byte enables.
REQ-013 Port m_gnt, output, NUM_MASTERS: one-hot grant pulse.
REQ-014 Port m_rvalid, output, NUM_MASTERS: one-hot read-data-valid pulse.
REQ-015 Port m_rdata, output, DATA_WIDTH: shared read data; qualified by m_rvalid.
REQ-016 Ports mem_ce, mem_we (output, 1), mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH), mem_be (output, DATA_WIDTH/8), mem_rdata (input, DATA_WIDTH): single memory port.

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE, WAIT; only one transaction is outstanding at a time.
REQ-018 In IDLE with any m_req bit set, the block SHALL select a winner round-robin, searching upward from last_grant+1 modulo NUM_MASTERS, latch its we/addr/wdata/be, and enter ISSUE.
REQ-019 In IDLE with m_req all zero, the block SHALL stay in IDLE with all outputs at their idle values.
REQ-020 In ISSUE, the block SHALL assert mem_ce=1 and drive the latched mem_we/mem_addr/mem_wdata/mem_be for exactly one cycle, assert m_gnt[winner]=1 for that cycle, and set last_grant=winner.
REQ-021 After ISSUE, a write SHALL return to IDLE; a read SHALL enter WAIT.
REQ-022 In WAIT, the block SHALL count MEM_LATENCY-1 further cycles, sample mem_rdata MEM_LATENCY cycles after the ISSUE cycle, then on the next cycle drive m_rdata with the sampled value and pulse m_rvalid[winner] for one cycle, and return to IDLE.
REQ-023 Read latency SHALL be request-in-IDLE to m_rvalid = MEM_LATENCY+2 cycles; write request-to-grant SHALL be 1 cycle.
REQ-024 Outside ISSUE, mem_ce, mem_we and mem_be SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-025 m_rdata SHALL hold its last value when m_rvalid is zero.
REQ-026 Requests SHALL be sampled only in IDLE; a master deasserting m_req after the IDLE sample cycle SHALL still have its transaction completed.
REQ-027 A master SHALL hold m_req and its fields stable until it sees m_gnt; the block SHALL NOT grant the same request twice.
REQ-028 With simultaneous requests, each of NUM_MASTERS continuously requesting masters SHALL be granted exactly once per NUM_MASTERS grants.
REQ-029 At most one bit of m_gnt and one bit of m_rvalid SHALL be set in any cycle.

Reset
REQ-030 With rst=0, the block SHALL immediately enter IDLE and clear m_gnt, m_rvalid, m_rdata, mem_ce, mem_we, mem_addr, mem_wdata and mem_be to 0.
REQ-031 Reset SHALL set last_grant to NUM_MASTERS-1 so that master 0 has first priority.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction with no m_rvalid pulse; operation SHALL resume from IDLE at the first edge after rst returns to 1.

Verification
REQ-033 Defaults; master 0 writes addr 0x10, data 0xDEADBEEF, be 0xF -> next cycle mem_ce=1, mem_we=1, mem_addr=0x10, m_gnt=2'b01; FSM back in IDLE the cycle after.
REQ-034 MEM_LATENCY=2; master 1 reads 0x10, memory returns 0xDEADBEEF -> m_rvalid=2'b10 with m_rdata=0xDEADBEEF exactly 4 cycles after the request was sampled.
REQ-035 Both masters hold continuous reads from reset -> grant order 0,1,0,1; no master granted twice in a row.
REQ-036 NUM_MASTERS=4; only masters 1 and 3 request, last_grant=1 -> next grant goes to 3, then 1.
REQ-037 rst pulsed low during WAIT of a read -> all outputs 0 at once; no m_rvalid pulse; a new request after release is granted to master 0 first.
REQ-038 Write with m_be=4'b0101 -> mem_be=4'b0101 during ISSUE only; mem_be=0 in every other cycle.
